input_debounce_sync: RTL and testbench

- Top-level input conditioner that sits directly upstream of the SoC system. It feeds switches_0_external_connection_export[3:0] and the two myocontrol power_sense_n inputs.
- Each asynchronous board input is synchronised, debounced with a per-bit counter state machine, and presented as a glitch-free level.
- It also produces one-cycle rise/fall event pulses and a saturating per-bit toggle counter for debug readout.

---
 rtl/input_debounce_sync_if.sv | 25 ++
 rtl/input_debounce_sync.sv | 135 +++++++++++++
 tb/tb_input_debounce_sync.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/input_debounce_sync_if.sv
// Board-input conditioner bundle: raw inputs and controls in, debounced level, edge pulses and counters out.
// Latency: none (wiring only).
// Backpressure: none; all signals are level/pulse, no handshake.
interface input_debounce_sync_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]       din;
    logic                   enable;
    logic                   cnt_clr;
    logic [WIDTH-1:0]       dout;
    logic [WIDTH-1:0]       rise;
    logic [WIDTH-1:0]       fall;
    logic [WIDTH*CNT_W-1:0] toggle_cnt;

    modport master (
        output din, enable, cnt_clr,
        input  dout, rise, fall, toggle_cnt
    );

    modport slave (
        input  din, enable, cnt_clr,
        output dout, rise, fall, toggle_cnt
    );
endinterface

// File: rtl/input_debounce_sync.sv
// Per-bit synchroniser + counter debouncer with registered rise/fall pulses and saturating toggle counters.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from the first sampling edge to dout.
// Backpressure: none; enable=0 freezes the debounce FSMs while the synchroniser keeps sampling.
module input_debounce_sync #(
    parameter int               WIDTH           = 6,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0,
    parameter int               CNT_W           = 8
) (
    input logic               clk,
    input logic               reset,
    input_debounce_sync_if.slave io
);

    localparam int             DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DMAX = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [DW-1:0]    dcnt_q  [WIDTH];
    logic [DW-1:0]    dcnt_d  [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] accept;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = io.din;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_comb begin
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            cnt_d[i]   = cnt_q[i];
            // A disabled bit holds state and count; only the pulses are dropped.
            if (io.enable) begin
                case (state_q[i])
                    ST_STABLE: begin
                        if (s[i] != dout_q[i]) begin
                            state_d[i] = ST_PENDING;
                            dcnt_d[i]  = DW'(1);
                        end else begin
                            dcnt_d[i]  = '0;
                        end
                    end
                    ST_PENDING: begin
                        if (s[i] == dout_q[i]) begin
                            state_d[i] = ST_STABLE;
                            dcnt_d[i]  = '0;
                        end else if (dcnt_q[i] == DMAX) begin
                            dout_d[i]  = s[i];
                            rise_d[i]  = s[i];
                            fall_d[i]  = ~s[i];
                            accept[i]  = 1'b1;
                            state_d[i] = ST_STABLE;
                            dcnt_d[i]  = '0;
                        end else begin
                            dcnt_d[i]  = dcnt_q[i] + DW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_STABLE;
                        dcnt_d[i]  = '0;
                    end
                endcase
            end
            // Clear wins over a same-cycle accepted transition.
            if (io.cnt_clr) begin
                cnt_d[i] = '0;
            end else if (accept[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_LEVEL;
            end
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                dcnt_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
            dout_q <= RESET_LEVEL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign io.dout = dout_q;
    assign io.rise = rise_q;
    assign io.fall = fall_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
        assign io.toggle_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed bench for input_debounce_sync with DEBOUNCE_CYCLES=8, SYNC_STAGES=2, RESET_LEVEL=6'b110000.
module tb_input_debounce_sync;

    localparam int         W   = 6;
    localparam int         CW  = 8;
    localparam logic [5:0] RL  = 6'b110000;
    localparam int         LAT = 10;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [5:0] exp_dout;
    int         exp_cnt [W];

    input_debounce_sync_if #(.WIDTH(W), .CNT_W(CW)) io ();

    input_debounce_sync #(
        .WIDTH          (W),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .RESET_LEVEL    (RL),
        .CNT_W          (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W*CW-1:0] pack_cnt();
        logic [W*CW-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) p[i*CW +: CW] = CW'(exp_cnt[i]);
        return p;
    endfunction

    // Apply a clean change on din and check the edge lands exactly LAT edges later.
    task automatic watch(input logic [5:0] new_din, input string tag);
        logic [5:0] old, chg;
        old = exp_dout;
        chg = new_din ^ old;
        io.din = new_din;
        tick(LAT - 1);
        chk({tag, ":dout_pre"}, 64'(io.dout), 64'(old));
        chk({tag, ":pulse_pre"}, 64'(io.rise | io.fall), 64'd0);
        tick(1);
        chk({tag, ":dout"}, 64'(io.dout), 64'(new_din));
        chk({tag, ":rise"}, 64'(io.rise), 64'(chg & new_din));
        chk({tag, ":fall"}, 64'(io.fall), 64'(chg & old));
        tick(1);
        chk({tag, ":pulse_post"}, 64'(io.rise | io.fall), 64'd0);
        exp_dout = new_din;
        for (int i = 0; i < W; i++)
            if (chg[i] && exp_cnt[i] < 255) exp_cnt[i]++;
    endtask

    initial begin
        for (int i = 0; i < W; i++) exp_cnt[i] = 0;
        reset      = 1'b1;
        io.din     = RL;
        io.enable  = 1'b1;
        io.cnt_clr = 1'b0;
        exp_dout   = RL;
        tick(3);
        chk("rst:dout", 64'(io.dout), 64'(RL));
        reset = 1'b0;
        tick(12);
        chk("rel:dout", 64'(io.dout), 64'(RL));
        chk("rel:rise", 64'(io.rise), 64'd0);
        chk("rel:fall", 64'(io.fall), 64'd0);
        chk("rel:cnt", 64'(io.toggle_cnt), 64'd0);

        // Clean rise on bit 0.
        watch(6'b110001, "b0_rise");
        chk("b0:cnt", 64'(io.toggle_cnt[7:0]), 64'd1);

        // Bit 1 bounce: 5 cycles high, 2 low, then held high.
        io.din[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) io.din[1] = 1'b0;
            tick(1);
            chk("b1_bounce:dout", 64'(io.dout), 64'(exp_dout));
            chk("b1_bounce:pulse", 64'(io.rise | io.fall), 64'd0);
        end
        watch(6'b110011, "b1_final");
        chk("b1:cnt", 64'(io.toggle_cnt[15:8]), 64'd1);

        // Bits 2 and 3 together, up then down.
        watch(6'b111111, "b23_up");
        watch(6'b110011, "b23_down");
        chk("b2:cnt", 64'(io.toggle_cnt[23:16]), 64'd2);
        chk("b3:cnt", 64'(io.toggle_cnt[31:24]), 64'd2);

        // Saturation on bit 0: count goes 1 -> 254 -> 255 -> stays 255 (300 toggles).
        for (int k = 0; k < 253; k++) watch(exp_dout ^ 6'b000001, "b0_sat");
        chk("sat:254", 64'(io.toggle_cnt[7:0]), 64'd254);
        watch(exp_dout ^ 6'b000001, "b0_sat");
        chk("sat:255", 64'(io.toggle_cnt[7:0]), 64'd255);
        for (int k = 0; k < 46; k++) watch(exp_dout ^ 6'b000001, "b0_sat");
        chk("sat:hold", 64'(io.toggle_cnt[7:0]), 64'd255);
        chk("sat:all", 64'(io.toggle_cnt), 64'(pack_cnt()));

        // Clear on the same cycle bit 0 is accepted.
        io.din = exp_dout ^ 6'b000001;
        tick(LAT - 1);
        io.cnt_clr = 1'b1;
        tick(1);
        io.cnt_clr = 1'b0;
        exp_dout = exp_dout ^ 6'b000001;
        for (int i = 0; i < W; i++) exp_cnt[i] = 0;
        chk("clr:dout", 64'(io.dout), 64'(exp_dout));
        chk("clr:fall", 64'(io.fall), 64'(6'b000001));
        chk("clr:cnt", 64'(io.toggle_cnt), 64'd0);

        // Freeze bit 4 at dcnt=4 for 20 cycles.
        io.din = exp_dout & ~6'b010000;
        tick(6);
        io.enable = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 20; k++) begin
                tick(1);
                if ((io.rise | io.fall) != 0) pulses++;
            end
            chk("en:pulses", 64'(pulses), 64'd0);
        end
        chk("en:hold", 64'(io.dout), 64'(exp_dout));
        io.enable = 1'b1;
        tick(3);
        chk("en:pre", 64'(io.dout), 64'(exp_dout));
        tick(1);
        exp_dout[4] = 1'b0;
        exp_cnt[4]  = 1;
        chk("en:dout", 64'(io.dout), 64'(exp_dout));
        chk("en:fall", 64'(io.fall), 64'(6'b010000));
        chk("en:cnt", 64'(io.toggle_cnt), 64'(pack_cnt()));

        // Reset in the middle of pending transitions on bits 0 and 5.
        io.din = 6'b000011;
        tick(6);
        chk("rp:pre", 64'(io.dout), 64'(exp_dout));
        reset = 1'b1;
        #2;
        chk("rp:dout", 64'(io.dout), 64'(RL));
        chk("rp:pulse", 64'(io.rise | io.fall), 64'd0);
        chk("rp:cnt", 64'(io.toggle_cnt), 64'd0);
        io.din = RL;
        tick(2);
        reset = 1'b0;
        tick(15);
        chk("rp:after", 64'(io.dout), 64'(RL));
        chk("rp:after_cnt", 64'(io.toggle_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
